fwd_ctrl: RTL and testbench
===========================

FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high; clears all state.
REQ-004 id_valid  in  1  decode slot holds a real instruction.
REQ-005 id_rs1, id_rs2  in  5 each  source register indices of the decode instruction.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  decode instruction reads rs1 / rs2.
REQ-007 id_a_pc  in  1  decode instruction takes PC as operand A.
REQ-008 id_b_imm  in  1  decode instruction takes the immediate as operand B.
REQ-009 id_rd  in  5  destination register index of the decode instruction.
REQ-010 id_wen  in  1  decode instruction writes rd.
REQ-011 id_load  in  1  decode instruction is a load.
REQ-012 flush  in  1  taken branch/jump; the instruction entering EX this edge is killed.
REQ-013 stall  out  1  combinational; hold PC and IF/ID and insert a bubble into EX.
REQ-014 alu_a_sel  out  2  registered select for EX operand A: 00 rs1, 01 pc, 10 mem result, 11 wb result.
REQ-015 alu_b_sel  out  2  registered select for EX operand B: 00 rs2, 01 imm, 10 mem result, 11 wb result.
REQ-016 stall_count  out  16  registered, saturating count of stall cycles.

Function
REQ-017 The block SHALL keep two tracking slots, EX and MEM, each holding {valid, rd, wen, load}.
REQ-018 On every clock edge, MEM SHALL take EX and EX SHALL take the new entry; the pipeline downstream of decode never holds.
REQ-019 The new EX entry SHALL be the decode fields when id_valid=1, stall=0 and flush=0; otherwise it SHALL be a bubble (valid=0, wen=0, load=0, rd=0).
REQ-020 A slot SHALL count as a producer for register r only when valid=1, wen=1, rd=r and r!=0.
REQ-021 stall SHALL be 1 exactly when id_valid=1, flush=0, the EX slot is a load producer, and it produces id_rs1 (with id_use_rs1=1) or id_rs2 (with id_use_rs2=1).
REQ-022 A stall SHALL last one cycle per load-use pair; on the next cycle the load sits in MEM and stall SHALL drop unless a new EX load hazard exists.
REQ-023 The operand A select registered at the edge SHALL be 01 if id_a_pc=1.
REQ-024 Otherwise, if id_use_rs1=1 and the current EX slot produces id_rs1, the operand A select SHALL be 10.
REQ-025 Otherwise, if id_use_rs1=1 and the current MEM slot produces id_rs1, the operand A select SHALL be 11.
REQ-026 In every remaining case the operand A select SHALL be 00.
REQ-027 alu_b_sel SHALL follow the same priority (REQ-023 to REQ-026), using id_b_imm, id_use_rs2 and id_rs2 in place of the operand A inputs.
REQ-028 The nearest producer SHALL win: EX (forwarded as mem, 10) has priority over MEM (forwarded as wb, 11).
REQ-029 When a bubble enters EX (stall, flush or id_valid=0), alu_a_sel and alu_b_sel SHALL register 00.
REQ-030 flush SHALL take priority over stall: with flush=1, stall is 0 and the EX entry is a bubble.
REQ-031 stall_count SHALL increment by 1 on each edge where stall=1, saturating at 16'hFFFF without wrapping.
REQ-032 A load in the MEM slot SHALL never cause a stall; a MEM-slot load producer is forwarded via select 11.

Reset
REQ-033 While reset=1, the EX and MEM slots SHALL be invalid, alu_a_sel and alu_b_sel SHALL be 00, and stall_count SHALL be 0, regardless of clock.
REQ-034 While reset=1, stall SHALL be 0.
REQ-035 A reset asserted mid-stall SHALL discard the pending hazard; the first instruction after reset SHALL see no producers.

Verification
REQ-036 ALU-to-ALU forwarding: add x5 then add x6,x5,x5 on consecutive cycles -> second instruction in EX with alu_a_sel=10, alu_b_sel=10, stall=0.
REQ-037 Gap of one instruction: add x5, nop, sub x7,x5,x1 -> sub in EX with alu_a_sel=11, alu_b_sel=00.
REQ-038 Load-use: lw x8 then add x9,x8,x0 -> stall=1 for one cycle, bubble in EX (sels 00), then add in EX with alu_a_sel=11, stall_count=1.
REQ-039 Register x0 and priority: producers writing x0 -> sels stay 00. Producers in both EX and MEM writing x3 -> consumer gets 10.
REQ-040 Flush during hazard: lw x8 in EX, dependent add in decode, flush=1 -> stall=0, EX bubble, stall_count unchanged.
REQ-041 Reset mid-operation and saturation: reset asserted asynchronously mid-stream -> outputs 0 immediately. Forced stall_count=16'hFFFF with a further stall -> stays 16'hFFFF.

Source files
------------

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: load-use stall detection and EX operand forwarding select generation
module fwd_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_a_pc,
  input  logic        id_b_imm,
  input  logic [4:0]  id_rd,
  input  logic        id_wen,
  input  logic        id_load,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [15:0] stall_count
);
  logic       ex_valid, ex_wen, ex_load, mem_valid, mem_wen, mem_load;
  logic [4:0] ex_rd, mem_rd;
  logic       ex_p1, ex_p2, mem_p1, mem_p2, take;
  logic [1:0] a_nxt, b_nxt;
  logic [15:0] cnt_q;
  assign ex_p1  = ex_valid && ex_wen && ex_rd == id_rs1 && id_rs1 != 5'd0;
  assign ex_p2  = ex_valid && ex_wen && ex_rd == id_rs2 && id_rs2 != 5'd0;
  assign mem_p1 = mem_valid && mem_wen && mem_rd == id_rs1 && id_rs1 != 5'd0;
  assign mem_p2 = mem_valid && mem_wen && mem_rd == id_rs2 && id_rs2 != 5'd0;
  assign stall  = !reset && id_valid && !flush && ex_load &&
                  ((id_use_rs1 && ex_p1) || (id_use_rs2 && ex_p2));
  assign take   = id_valid && !stall && !flush;
  assign stall_count = cnt_q;
  // Operand selects for the instruction entering EX; a bubble always selects 00
  always_comb begin
    a_nxt = !take ? 2'b00 : id_a_pc ? 2'b01 : (id_use_rs1 && ex_p1) ? 2'b10 :
            (id_use_rs1 && mem_p1) ? 2'b11 : 2'b00;
    b_nxt = !take ? 2'b00 : id_b_imm ? 2'b01 : (id_use_rs2 && ex_p2) ? 2'b10 :
            (id_use_rs2 && mem_p2) ? 2'b11 : 2'b00;
  end
  // Advance the EX/MEM tracking slots every edge and count stall cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_wen    <= 1'b0;
      ex_load   <= 1'b0;
      ex_rd     <= 5'd0;
      mem_valid <= 1'b0;
      mem_wen   <= 1'b0;
      mem_load  <= 1'b0;
      mem_rd    <= 5'd0;
      alu_a_sel <= 2'b00;
      alu_b_sel <= 2'b00;
      cnt_q     <= 16'd0;
    end else begin
      mem_valid <= ex_valid;
      mem_wen   <= ex_wen;
      mem_load  <= ex_load;
      mem_rd    <= ex_rd;
      ex_valid  <= take;
      ex_wen    <= take && id_wen;
      ex_load   <= take && id_load;
      ex_rd     <= take ? id_rd : 5'd0;
      alu_a_sel <= a_nxt;
      alu_b_sel <= b_nxt;
      if (stall && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed scoreboard bench for fwd_ctrl forwarding and stall behaviour
module tb_fwd_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic        id_a_pc = 1'b0, id_b_imm = 1'b0, id_wen = 1'b0, id_load = 1'b0, flush = 1'b0;
  logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic        stall;
  logic [1:0]  alu_a_sel, alu_b_sel;
  logic [15:0] stall_count;
  logic [3:0]  sb_q[$];
  int          n_cmp = 0, n_err = 0;

  localparam logic [6:0] U1 = 7'b1000000, U2 = 7'b0100000, APC = 7'b0010000,
                         IMM = 7'b0001000, WEN = 7'b0000100, LD = 7'b0000010, FL = 7'b0000001;

  fwd_ctrl dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_a_pc(id_a_pc), .id_b_imm(id_b_imm),
    .id_rd(id_rd), .id_wen(id_wen), .id_load(id_load), .flush(flush), .stall(stall),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one decode slot, check stall before the edge, check registered selects after it
  task automatic issue(input string tag, input logic v, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [6:0] f, input logic es,
                       input logic [1:0] ea, input logic [1:0] eb);
    logic [3:0] e;
    id_valid = v; id_rd = rd; id_rs1 = r1; id_rs2 = r2;
    {id_use_rs1, id_use_rs2, id_a_pc, id_b_imm, id_wen, id_load, flush} = f;
    #1;
    check({tag, ".stall"}, {15'd0, stall}, {15'd0, es});
    sb_q.push_back({ea, eb});
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".a_sel"}, {14'd0, alu_a_sel}, {14'd0, e[3:2]});
      check({tag, ".b_sel"}, {14'd0, alu_b_sel}, {14'd0, e[1:0]});
    end
  endtask

  initial begin
    #1;
    check("rst.stall", {15'd0, stall}, 16'd0);
    @(posedge clock); @(posedge clock); #1;
    check("rst.a_sel", {14'd0, alu_a_sel}, 16'd0);
    check("rst.b_sel", {14'd0, alu_b_sel}, 16'd0);
    check("rst.count", stall_count, 16'd0);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    // ALU-to-ALU forwarding
    issue("add_x5", 1, 5'd5, 5'd1, 5'd2, U1|U2|WEN, 0, 2'd0, 2'd0);
    issue("add_x6", 1, 5'd6, 5'd5, 5'd5, U1|U2|WEN, 0, 2'd2, 2'd2);
    // one-instruction gap forwards from MEM
    issue("add_x5b", 1, 5'd5, 5'd1, 5'd2, U1|U2|WEN, 0, 2'd0, 2'd0);
    issue("nop", 0, 5'd0, 5'd0, 5'd0, 7'd0, 0, 2'd0, 2'd0);
    issue("sub_x7", 1, 5'd7, 5'd5, 5'd1, U1|U2|WEN, 0, 2'd3, 2'd0);
    // load-use stall then MEM forwarding of the load
    issue("lw_x8", 1, 5'd8, 5'd2, 5'd0, U1|IMM|WEN|LD, 0, 2'd0, 2'd1);
    issue("lu_stall", 1, 5'd9, 5'd8, 5'd0, U1|U2|WEN, 1, 2'd0, 2'd0);
    issue("lu_fwd", 1, 5'd9, 5'd8, 5'd0, U1|U2|WEN, 0, 2'd3, 2'd0);
    check("lu.count", stall_count, 16'd1);
    // x0 is never a producer
    issue("add_x0a", 1, 5'd0, 5'd1, 5'd2, U1|U2|WEN, 0, 2'd0, 2'd0);
    issue("add_x0b", 1, 5'd0, 5'd1, 5'd2, U1|U2|WEN, 0, 2'd0, 2'd0);
    issue("use_x0", 1, 5'd10, 5'd0, 5'd0, U1|U2|WEN, 0, 2'd0, 2'd0);
    // nearest producer wins
    issue("add_x3a", 1, 5'd3, 5'd1, 5'd2, U1|U2|WEN, 0, 2'd0, 2'd0);
    issue("add_x3b", 1, 5'd3, 5'd1, 5'd2, U1|U2|WEN, 0, 2'd0, 2'd0);
    issue("use_x3", 1, 5'd11, 5'd3, 5'd3, U1|U2|WEN, 0, 2'd2, 2'd2);
    // pc/imm override a live producer
    issue("pc_imm", 1, 5'd12, 5'd3, 5'd11, U1|U2|APC|IMM|WEN, 0, 2'd1, 2'd1);
    issue("add_x13", 1, 5'd13, 5'd0, 5'd3, U1|U2|WEN, 0, 2'd0, 2'd0);
    issue("b_wb", 1, 5'd14, 5'd1, 5'd12, U1|U2|WEN, 0, 2'd0, 2'd3);
    // non-writing instruction is not a producer
    issue("sw_x5", 1, 5'd5, 5'd1, 5'd2, U1|U2, 0, 2'd0, 2'd0);
    issue("use_sw", 1, 5'd15, 5'd5, 5'd5, U1|U2|WEN, 0, 2'd0, 2'd0);
    // flush beats stall
    issue("lw_f", 1, 5'd8, 5'd1, 5'd0, U1|IMM|WEN|LD, 0, 2'd0, 2'd1);
    issue("flush", 1, 5'd9, 5'd8, 5'd0, U1|U2|WEN|FL, 0, 2'd0, 2'd0);
    check("flush.count", stall_count, 16'd1);
    issue("post_fl", 1, 5'd9, 5'd8, 5'd0, U1|U2|WEN, 0, 2'd3, 2'd0);
    // rs2-only load-use, then unused rs2 match must not stall
    issue("lw_r2", 1, 5'd8, 5'd1, 5'd0, U1|IMM|WEN|LD, 0, 2'd0, 2'd1);
    issue("r2_stall", 1, 5'd9, 5'd1, 5'd8, U1|U2|WEN, 1, 2'd0, 2'd0);
    issue("r2_fwd", 1, 5'd9, 5'd1, 5'd8, U1|U2|WEN, 0, 2'd0, 2'd3);
    check("r2.count", stall_count, 16'd2);
    issue("lw_x20", 1, 5'd20, 5'd1, 5'd0, U1|IMM|WEN|LD, 0, 2'd0, 2'd1);
    issue("no_use2", 1, 5'd21, 5'd0, 5'd20, U1|WEN, 0, 2'd0, 2'd0);
    // asynchronous reset in the middle of a pending stall
    issue("lw_rst", 1, 5'd8, 5'd1, 5'd0, U1|IMM|WEN|LD, 0, 2'd0, 2'd1);
    id_rd = 5'd9; id_rs1 = 5'd8; id_rs2 = 5'd0;
    {id_use_rs1, id_use_rs2, id_a_pc, id_b_imm, id_wen, id_load, flush} = U1|U2|WEN;
    #1;
    check("pre_rst.stall", {15'd0, stall}, 16'd1);
    #2 reset = 1'b1;
    #1;
    check("arst.stall", {15'd0, stall}, 16'd0);
    check("arst.b_sel", {14'd0, alu_b_sel}, 16'd0);
    check("arst.count", stall_count, 16'd0);
    @(negedge clock); reset = 1'b0;
    issue("after_rst", 1, 5'd9, 5'd8, 5'd0, U1|U2|WEN, 0, 2'd0, 2'd0);
    // saturation of the stall counter
    force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    issue("lw_s1", 1, 5'd8, 5'd1, 5'd0, U1|IMM|WEN|LD, 0, 2'd0, 2'd1);
    issue("sat_st1", 1, 5'd9, 5'd8, 5'd0, U1|WEN, 1, 2'd0, 2'd0);
    check("sat.count1", stall_count, 16'hFFFF);
    issue("sat_go1", 1, 5'd9, 5'd8, 5'd0, U1|WEN, 0, 2'd3, 2'd0);
    issue("lw_s2", 1, 5'd8, 5'd1, 5'd0, U1|IMM|WEN|LD, 0, 2'd0, 2'd1);
    issue("sat_st2", 1, 5'd9, 5'd8, 5'd0, U1|WEN, 1, 2'd0, 2'd0);
    check("sat.count2", stall_count, 16'hFFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
